// File: rtl/fp_arb_pkg.sv
// Shared types and the round-robin search helper for the FP32 multiplier arbiter.
package fp_arb_pkg;

  localparam int C_FP_DWIDTH = 32;
  localparam int C_MAX_REQ   = 8;

  typedef logic [C_FP_DWIDTH-1:0] float_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Bits above the real requester count are zero, so a fixed 8-way wrap
  // visits requesters in the same order as a wrap at N-1.
  function automatic rr_pick_t rr_pick(input logic [C_MAX_REQ-1:0] valid,
                                       input logic [2:0]           ptr);
    rr_pick_t   res;
    logic [2:0] cand;
    res = '0;
    for (int k = 1; k <= C_MAX_REQ; k++) begin
      cand = ptr + 3'(k);
      if (!res.found && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_mult_tag_fifo.sv
// Synchronous FIFO holding the requester tag of every op issued to the multiplier.
module fp_mult_tag_fifo #(
  parameter int G_WIDTH = 2,
  parameter int G_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [G_WIDTH-1:0] din,
  output logic [G_WIDTH-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(G_DEPTH);
  localparam int CW = AW + 1;

  logic [G_WIDTH-1:0] mem [G_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(G_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin sharing of one pipelined FP32 multiplier; results routed back by tag.
// Optional per-requester accept counters when FP_MULT_ARB_STATS_EN is defined.
module fp_mult_arbiter
  import fp_arb_pkg::*;
#(
  parameter int G_NUM_REQ      = 4,
  parameter int G_MAX_INFLIGHT = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [G_NUM_REQ*C_FP_DWIDTH-1:0] req_din1,
  input  logic [G_NUM_REQ*C_FP_DWIDTH-1:0] req_din2,
  input  logic [G_NUM_REQ-1:0]             req_valid,
  output logic [G_NUM_REQ-1:0]             req_ready,
  output logic [C_FP_DWIDTH-1:0]           rsp_dout,
  output logic [G_NUM_REQ-1:0]             rsp_valid,
  output logic [C_FP_DWIDTH-1:0]           mult_din1,
  output logic [C_FP_DWIDTH-1:0]           mult_din2,
  output logic                             mult_din_valid,
  input  logic [C_FP_DWIDTH-1:0]           mult_dout,
  input  logic                             mult_dout_valid,
`ifdef FP_MULT_ARB_STATS_EN
  output logic [G_NUM_REQ*16-1:0]          stat_grants,
`endif
  output logic                             tag_err
);

  localparam int TW = $clog2(G_NUM_REQ);
  localparam int IW = $clog2(G_MAX_INFLIGHT) + 1;

  logic [TW-1:0]        rr_ptr;
  logic [IW-1:0]        inflight;
  logic [C_MAX_REQ-1:0] valid_ext;
  rr_pick_t             pick;
  logic                 accept;
  logic [TW-1:0]        grant_idx;
  float_t               sel_a;
  float_t               sel_b;
  logic [TW-1:0]        tag_out;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  // Grant is purely combinational; the granted requester is always one with valid set.
  always_comb begin
    valid_ext = '0;
    valid_ext[G_NUM_REQ-1:0] = req_valid;
    pick      = rr_pick(valid_ext, 3'(rr_ptr));
    grant_idx = TW'(pick.idx);
    accept    = !reset && enable && pick.found && (inflight < IW'(G_MAX_INFLIGHT));
    sel_a     = req_din1[grant_idx*C_FP_DWIDTH +: C_FP_DWIDTH];
    sel_b     = req_din2[grant_idx*C_FP_DWIDTH +: C_FP_DWIDTH];
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign pop = mult_dout_valid && !fifo_empty;

  fp_mult_tag_fifo #(
    .G_WIDTH (TW),
    .G_DEPTH (G_MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (!enable),
    .push  (accept),
    .pop   (pop),
    .din   (grant_idx),
    .dout  (tag_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr         <= TW'(G_NUM_REQ - 1);
      inflight       <= '0;
      mult_din1      <= '0;
      mult_din2      <= '0;
      mult_din_valid <= 1'b0;
      rsp_dout       <= '0;
      rsp_valid      <= '0;
      tag_err        <= 1'b0;
    end else if (!enable) begin
      rr_ptr         <= TW'(G_NUM_REQ - 1);
      inflight       <= '0;
      mult_din1      <= '0;
      mult_din2      <= '0;
      mult_din_valid <= 1'b0;
      rsp_dout       <= '0;
      rsp_valid      <= '0;
      tag_err        <= 1'b0;
    end else begin
      mult_din_valid <= accept;
      if (accept) begin
        rr_ptr    <= grant_idx;
        mult_din1 <= sel_a;
        mult_din2 <= sel_b;
      end
      if (accept && !pop)      inflight <= inflight + 1'b1;
      else if (!accept && pop) inflight <= inflight - 1'b1;
      rsp_valid <= '0;
      if (pop) begin
        rsp_valid[tag_out] <= 1'b1;
        rsp_dout           <= mult_dout;
      end
      // A result with no outstanding tag cannot be routed, so it is dropped and flagged.
      if (mult_dout_valid && fifo_empty) tag_err <= 1'b1;
    end
  end

`ifdef FP_MULT_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants <= '0;
    end else if (!enable) begin
      stat_grants <= '0;
    end else begin
      for (int i = 0; i < G_NUM_REQ; i++) begin
        if (req_ready[i] && stat_grants[16*i +: 16] != 16'hFFFF)
          stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

  // fifo_full is redundant with the inflight limit but kept for visibility in waves.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter with a latency-4 FP32 multiplier model.
// Build with FP_MULT_ARB_STATS_EN defined to also exercise stat_grants.
module tb_fp_mult_arbiter;

  localparam int N = 4;
  localparam int L = 4;

  typedef struct packed {
    logic [N-1:0] onehot;
    logic [31:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;

  logic [N*32-1:0] req_din1 = '0;
  logic [N*32-1:0] req_din2 = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [31:0]     rsp_dout;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     mult_din1, mult_din2, mult_dout;
  logic            mult_din_valid, mult_dout_valid;
  logic            tag_err;

  logic [N*32-1:0] s_req_din1 = '0;
  logic [N*32-1:0] s_req_din2 = '0;
  logic [N-1:0]    s_req_valid = '0;
  logic [N-1:0]    s_req_ready;
  logic [31:0]     s_rsp_dout;
  logic [N-1:0]    s_rsp_valid;
  logic [31:0]     s_mult_din1, s_mult_din2, s_mult_dout;
  logic            s_mult_din_valid, s_mult_dout_valid;
  logic            s_tag_err;

`ifdef FP_MULT_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [N*16-1:0] s_stat_grants;
`endif

  logic        inj_valid = 1'b0;
  logic [31:0] inj_data = '0;

  exp_t sb[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.G_NUM_REQ(N), .G_MAX_INFLIGHT(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_din1(req_din1), .req_din2(req_din2), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_dout(rsp_dout), .rsp_valid(rsp_valid),
    .mult_din1(mult_din1), .mult_din2(mult_din2), .mult_din_valid(mult_din_valid),
    .mult_dout(mult_dout), .mult_dout_valid(mult_dout_valid),
`ifdef FP_MULT_ARB_STATS_EN
    .stat_grants(stat_grants),
`endif
    .tag_err(tag_err)
  );

  fp_mult_arbiter #(.G_NUM_REQ(N), .G_MAX_INFLIGHT(4)) dut_s (
    .clk(clk), .reset(reset), .enable(enable),
    .req_din1(s_req_din1), .req_din2(s_req_din2), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .rsp_dout(s_rsp_dout), .rsp_valid(s_rsp_valid),
    .mult_din1(s_mult_din1), .mult_din2(s_mult_din2), .mult_din_valid(s_mult_din_valid),
    .mult_dout(s_mult_dout), .mult_dout_valid(s_mult_dout_valid),
`ifdef FP_MULT_ARB_STATS_EN
    .stat_grants(s_stat_grants),
`endif
    .tag_err(s_tag_err)
  );

  // Truncating FP32 multiply for normal operands, good enough for the exact products used here.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:0] == '0 || b[30:0] == '0) return {a[31] ^ b[31], 31'b0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  logic [L-1:0] m_v = '0;
  logic [31:0]  m_d [L];
  logic [L-1:0] s_m_v = '0;
  logic [31:0]  s_m_d [L];

  // Multiplier models: valid-only pipelines of depth L, unaffected by the arbiter reset.
  always @(posedge clk) begin
    m_v     <= {m_v[L-2:0], mult_din_valid};
    m_d[0]  <= fp_mul(mult_din1, mult_din2);
    s_m_v   <= {s_m_v[L-2:0], s_mult_din_valid};
    s_m_d[0] <= fp_mul(s_mult_din1, s_mult_din2);
    for (int k = 1; k < L; k++) begin
      m_d[k]   <= m_d[k-1];
      s_m_d[k] <= s_m_d[k-1];
    end
  end

  assign mult_dout_valid   = m_v[L-1] | inj_valid;
  assign mult_dout         = inj_valid ? inj_data : m_d[L-1];
  assign s_mult_dout_valid = s_m_v[L-1];
  assign s_mult_dout       = s_m_d[L-1];

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    s_req_valid = '1;
    #3;
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_dout !== '0 || mult_din_valid !== 1'b0 || tag_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: ready=%b rsp_valid=%b rsp_dout=%h din_valid=%b tag_err=%b, required all zero",
               req_ready, rsp_valid, rsp_dout, mult_din_valid, tag_err);
    end
    n_checks++;
    if (s_req_ready !== '0 || s_rsp_valid !== '0 || s_tag_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs_small: ready=%b rsp_valid=%b tag_err=%b, required all zero",
               s_req_ready, s_rsp_valid, s_tag_err);
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    s_req_valid = '0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || mult_din_valid !== 1'b0 || rsp_valid !== '0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: ready=%b din_valid=%b rsp_valid=%b, required 0", req_ready, mult_din_valid, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a_tab [N];
    logic [31:0] p_tab [N];
    logic [N-1:0] exp_ready;
    a_tab = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    p_tab = '{32'h3FC00000, 32'h40400000, 32'h40900000, 32'h40C00000};
    for (int i = 0; i < N; i++) begin
      req_din1[32*i +: 32] = a_tab[i];
      req_din2[32*i +: 32] = 32'h3FC00000;
    end
    @(posedge clk);
    #1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_ready = N'(1) << (k % N);
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL rr_grant[%0d]: req_ready=%b, required %b", k, req_ready, exp_ready);
      end
      sb.push_back({exp_ready, p_tab[k % N]});
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    for (int w = 0; w < 40 && sb.size() != 0; w++) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rr_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_single_latency();
    int lat;
    bit found;
    @(posedge clk);
    #1;
    req_din1[31:0] = 32'h3FC00000;
    req_din2[31:0] = 32'h40000000;
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL single_grant: req_ready=%b, required 0001", req_ready);
    end
    sb.push_back({4'b0001, 32'h40400000});
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    found = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (mult_din_valid !== 1'b1 || mult_din1 !== 32'h3FC00000 || mult_din2 !== 32'h40000000) begin
          n_fail++;
          $display("[TB] FAIL issue_reg: din_valid=%b din1=%h din2=%h, required 1 3fc00000 40000000",
                   mult_din_valid, mult_din1, mult_din2);
        end
      end
      if (rsp_valid !== '0) begin
        found = 1'b1;
        lat = c;
      end
    end
    n_checks++;
    if (lat != 2 + L || rsp_valid !== 4'b0001 || rsp_dout !== 32'h40400000) begin
      n_fail++;
      $display("[TB] FAIL single_latency: latency=%0d rsp_valid=%b rsp_dout=%h, required %0d 0001 40400000",
               lat, rsp_valid, rsp_dout, 2 + L);
    end
  endtask

  task automatic test_inflight_limit();
    logic [12:0] pat;
    int n_rsp;
    pat = 13'b1001111001111;
    n_rsp = 0;
    s_req_din1[63:32] = 32'h40000000;
    s_req_din2[63:32] = 32'h40400000;
    @(posedge clk);
    #1;
    s_req_valid = 4'b0010;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      if (c < 13) begin
        n_checks++;
        if (s_req_ready !== (pat[c] ? 4'b0010 : 4'b0000)) begin
          n_fail++;
          $display("[TB] FAIL limit_ready[%0d]: req_ready=%b, required %b", c, s_req_ready, pat[c] ? 4'b0010 : 4'b0000);
        end
      end
      if (s_rsp_valid !== '0) begin
        n_rsp++;
        n_checks++;
        if (s_rsp_valid !== 4'b0010 || s_rsp_dout !== 32'h40C00000) begin
          n_fail++;
          $display("[TB] FAIL limit_rsp: rsp_valid=%b rsp_dout=%h, required 0010 40c00000", s_rsp_valid, s_rsp_dout);
        end
      end
      @(posedge clk);
      #1;
      if (c == 12) s_req_valid = '0;
    end
    n_checks++;
    if (n_rsp != 9) begin
      n_fail++;
      $display("[TB] FAIL limit_count: %0d responses, required 9", n_rsp);
    end
  endtask

  task automatic test_tag_err();
    @(posedge clk);
    #1;
    inj_valid = 1'b1;
    inj_data = 32'h12345678;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tag_err !== 1'b1 || rsp_valid !== '0) begin
      n_fail++;
      $display("[TB] FAIL tag_err_set: tag_err=%b rsp_valid=%b, required 1 0000", tag_err, rsp_valid);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (tag_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL tag_err_sticky: tag_err=%b, required 1", tag_err);
    end
  endtask

  task automatic test_async_reset();
    req_din1[31:0] = 32'h40400000;
    req_din2[31:0] = 32'h3F000000;
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0001) begin
        n_fail++;
        $display("[TB] FAIL areset_grant[%0d]: req_ready=%b, required 0001", k, req_ready);
      end
      sb.push_back({4'b0001, 32'h3FC00000});
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_dout !== '0 || mult_din_valid !== 1'b0 || tag_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset_outputs: ready=%b rsp_valid=%b rsp_dout=%h din_valid=%b tag_err=%b, required all zero",
               req_ready, rsp_valid, rsp_dout, mult_din_valid, tag_err);
    end
    sb.delete();
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (tag_err !== 1'b0 || rsp_valid !== '0) begin
      n_fail++;
      $display("[TB] FAIL areset_late_results: tag_err=%b rsp_valid=%b, required 0 0000", tag_err, rsp_valid);
    end
  endtask

  task automatic test_enable_clear();
    @(posedge clk);
    #1;
    inj_valid = 1'b1;
    @(posedge clk);
    #1;
    inj_valid = 1'b0;
    req_din1[95:64] = 32'h40400000;
    req_din2[95:64] = 32'h3FC00000;
    req_valid = 4'b0100;
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0 || tag_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL enable_low: req_ready=%b tag_err=%b, required 0000 1", req_ready, tag_err);
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tag_err !== 1'b0 || req_ready !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL enable_clear: tag_err=%b req_ready=%b, required 0 0100", tag_err, req_ready);
    end
    sb.push_back({4'b0100, 32'h40900000});
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int w = 0; w < 40 && sb.size() != 0; w++) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL enable_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

`ifdef FP_MULT_ARB_STATS_EN
  task automatic test_stats();
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sb.push_back({4'b0100, 32'h40900000});
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    for (int w = 0; w < 40 && sb.size() != 0; w++) @(posedge clk);
    #1;
    n_checks++;
    if (stat_grants !== 64'h0000_0005_0000_0000 || sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL stat_grants: value=%h outstanding=%0d, required 0000000500000000 0", stat_grants, sb.size());
    end
  endtask
`endif

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset && rsp_valid !== '0) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_rsp: rsp_valid=%b rsp_dout=%h, required no response", rsp_valid, rsp_dout);
          end else begin
            e_mon = sb.pop_front();
            if (rsp_valid !== e_mon.onehot || rsp_dout !== e_mon.data) begin
              n_fail++;
              $display("[TB] FAIL scoreboard: rsp_valid=%b rsp_dout=%h, required %b %h",
                       rsp_valid, rsp_dout, e_mon.onehot, e_mon.data);
            end
          end
        end
      end
      begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "[TB] timeout");
      end
    join_none
    test_reset();
    test_round_robin();
    test_single_latency();
    test_inflight_limit();
    test_tag_err();
    test_async_reset();
    test_enable_clear();
`ifdef FP_MULT_ARB_STATS_EN
    test_stats();
`endif
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
